// File: rtl/nodf_status_pkg.sv
// Shared types and default widths for the non-dataflow ap_ctrl status tracker.
package nodf_status_pkg;

    localparam int unsigned DEF_CNT_W = 32;
    localparam int unsigned DEF_LAT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_WAIT_CONT = 2'd2,
        ST_FINISHED  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        EVT_START  = 2'd0,
        EVT_READY  = 2'd1,
        EVT_DONE   = 2'd2,
        EVT_FINISH = 2'd3
    } evt_kind_t;

endpackage

// File: rtl/nodf_sat_counter.sv
// Saturating up-counter with enable and synchronous active-high reset.
module nodf_sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/nodf_module_status_tracker.sv
// Passive ap_ctrl handshake tracker for one non-dataflow HLS module.
// Optional event log outputs are enabled with the NODF_EVENT_LOG_EN macro.
module nodf_module_status_tracker
    import nodf_status_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned LAT_W = DEF_LAT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             finish,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] start_cnt,
    output logic [CNT_W-1:0] ready_cnt,
    output logic [CNT_W-1:0] done_cnt,
    output logic [CNT_W-1:0] busy_cycles,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [LAT_W-1:0] last_latency,
    output logic             finished
`ifdef NODF_EVENT_LOG_EN
    ,
    output logic             evt_valid,
    output logic [1:0]       evt_kind,
    output logic [CNT_W-1:0] evt_time
`endif
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] start_ts_q;
    logic [LAT_W-1:0] last_latency_q;
    logic             finished_q;

    logic active;
    logic start_acc;
    logic done_ev;
    logic busy_en;
    logic stall_en;
    logic ready_en;

    assign active = (state_q != ST_FINISHED);

    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        done_ev   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ap_start) begin
                    start_acc = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ap_done) begin
                    done_ev = 1'b1;
                    if (!ap_continue) begin
                        state_d = ST_WAIT_CONT;
                    end else if (ap_start) begin
                        start_acc = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT_CONT: begin
                if (ap_continue) begin
                    start_acc = ap_start;
                    state_d   = ap_start ? ST_RUN : ST_IDLE;
                end
            end
            default: ;
        endcase
        if (finish) begin
            state_d = ST_FINISHED;
        end
    end

    // Busy spans the accepting cycle through the done cycle, so one
    // isolated transaction adds last_latency + 1 busy cycles.
    assign busy_en  = (state_q == ST_RUN) || start_acc;
    assign stall_en = (state_q == ST_WAIT_CONT);
    assign ready_en = ap_ready && active;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cycle_q        <= '0;
            start_ts_q     <= '0;
            last_latency_q <= '0;
            finished_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (active) begin
                cycle_q <= cycle_q + CNT_W'(1);
            end
            if (start_acc) begin
                start_ts_q <= cycle_q;
            end
            if (done_ev) begin
                last_latency_q <= LAT_W'(cycle_q - start_ts_q);
            end
            if (finish) begin
                finished_q <= 1'b1;
            end
        end
    end

    nodf_sat_counter #(.W(CNT_W)) u_start_cnt (
        .clock(clock), .reset(reset), .en(start_acc), .count(start_cnt)
    );
    nodf_sat_counter #(.W(CNT_W)) u_ready_cnt (
        .clock(clock), .reset(reset), .en(ready_en), .count(ready_cnt)
    );
    nodf_sat_counter #(.W(CNT_W)) u_done_cnt (
        .clock(clock), .reset(reset), .en(done_ev), .count(done_cnt)
    );
    nodf_sat_counter #(.W(CNT_W)) u_busy_cycles (
        .clock(clock), .reset(reset), .en(busy_en), .count(busy_cycles)
    );
    nodf_sat_counter #(.W(CNT_W)) u_stall_cycles (
        .clock(clock), .reset(reset), .en(stall_en), .count(stall_cycles)
    );

    assign state        = state_q;
    assign cycle_cnt    = cycle_q;
    assign last_latency = last_latency_q;
    assign finished     = finished_q;

`ifdef NODF_EVENT_LOG_EN
    evt_kind_t        evt_kind_q;
    logic             evt_valid_q;
    logic [CNT_W-1:0] evt_time_q;

    // One log entry per cycle: finish > done > start > ready.
    always_ff @(posedge clock) begin
        if (reset) begin
            evt_valid_q <= 1'b0;
            evt_kind_q  <= EVT_START;
            evt_time_q  <= '0;
        end else begin
            evt_valid_q <= 1'b0;
            evt_time_q  <= cycle_q;
            if (active) begin
                if (finish) begin
                    evt_valid_q <= 1'b1;
                    evt_kind_q  <= EVT_FINISH;
                end else if (done_ev) begin
                    evt_valid_q <= 1'b1;
                    evt_kind_q  <= EVT_DONE;
                end else if (start_acc) begin
                    evt_valid_q <= 1'b1;
                    evt_kind_q  <= EVT_START;
                end else if (ap_ready) begin
                    evt_valid_q <= 1'b1;
                    evt_kind_q  <= EVT_READY;
                end
            end
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_kind  = evt_kind_q;
    assign evt_time  = evt_time_q;
`endif

endmodule

// File: tb/tb_nodf_module_status_tracker.sv
// Self-checking bench for nodf_module_status_tracker: directed vector table,
// hand sequences and a randomized run against a transaction-level model.
module tb_nodf_module_status_tracker;

    localparam int CW = 8;
    localparam int LW = 6;
    localparam int unsigned CMAX  = (1 << CW) - 1;
    localparam int unsigned LMASK = (1 << LW) - 1;

    logic          clock;
    logic          reset;
    logic          ap_start, ap_ready, ap_done, ap_continue, finish;
    logic [1:0]    state;
    logic [CW-1:0] cycle_cnt, start_cnt, ready_cnt, done_cnt, busy_cycles, stall_cycles;
    logic [LW-1:0] last_latency;
    logic          finished;
`ifdef NODF_EVENT_LOG_EN
    logic          evt_valid;
    logic [1:0]    evt_kind;
    logic [CW-1:0] evt_time;
`endif

    int checks = 0;
    int errors = 0;

    nodf_module_status_tracker #(.CNT_W(CW), .LAT_W(LW)) dut (
        .clock(clock), .reset(reset),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .ap_continue(ap_continue), .finish(finish),
        .state(state), .cycle_cnt(cycle_cnt), .start_cnt(start_cnt),
        .ready_cnt(ready_cnt), .done_cnt(done_cnt), .busy_cycles(busy_cycles),
        .stall_cycles(stall_cycles), .last_latency(last_latency), .finished(finished)
`ifdef NODF_EVENT_LOG_EN
        , .evt_valid(evt_valid), .evt_kind(evt_kind), .evt_time(evt_time)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit s, input bit rd, input bit dn, input bit ct, input bit fz);
        reset = r; ap_start = s; ap_ready = rd; ap_done = dn; ap_continue = ct; finish = fz;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---------------- transaction-level reference model ----------------
    // Phase codes follow the state output: 0 idle, 1 running, 2 awaiting continue, 3 frozen.
    int unsigned m_cyc, m_start, m_ready, m_done, m_busy, m_stall, m_lat, m_ts;
    int          m_phase;
    bit          m_fin;
    bit          m_ev_v;
    int          m_ev_k;
    int unsigned m_ev_t;

    function automatic int unsigned sat_inc(input int unsigned v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_reset();
        m_cyc = 0; m_start = 0; m_ready = 0; m_done = 0; m_busy = 0; m_stall = 0;
        m_lat = 0; m_ts = 0; m_phase = 0; m_fin = 0; m_ev_v = 0; m_ev_k = 0; m_ev_t = 0;
    endtask

    task automatic model_step(input bit r, input bit s, input bit rd, input bit dn, input bit ct, input bit fz);
        bit accepted, completed;
        int nxt;
        if (r) begin
            model_reset();
            return;
        end
        m_ev_v = 0;
        if (m_phase == 3) return;
        accepted  = 0;
        completed = 0;
        nxt       = m_phase;
        if (m_phase == 0 && s) begin
            accepted = 1; nxt = 1;
        end else if (m_phase == 1 && dn) begin
            completed = 1;
            if (!ct)     nxt = 2;
            else if (s)  accepted = 1;
            else         nxt = 0;
        end else if (m_phase == 2 && ct) begin
            accepted = s;
            nxt = s ? 1 : 0;
        end
        if (m_phase == 1 || accepted) m_busy = sat_inc(m_busy);
        if (m_phase == 2) m_stall = sat_inc(m_stall);
        if (rd) m_ready = sat_inc(m_ready);
        if (completed) begin
            m_done = sat_inc(m_done);
            m_lat  = (m_cyc - m_ts) & LMASK;
        end
        if (accepted) begin
            m_start = sat_inc(m_start);
            m_ts    = m_cyc;
        end
        m_ev_t = m_cyc;
        if (fz)             begin m_ev_v = 1; m_ev_k = 3; end
        else if (completed) begin m_ev_v = 1; m_ev_k = 2; end
        else if (accepted)  begin m_ev_v = 1; m_ev_k = 0; end
        else if (rd)        begin m_ev_v = 1; m_ev_k = 1; end
        m_cyc = (m_cyc + 1) & CMAX;
        if (fz) begin
            nxt = 3;
            m_fin = 1;
        end
        m_phase = nxt;
    endtask

    task automatic check_model(input int idx);
        chk($sformatf("rand%0d state", idx), state, m_phase);
        chk($sformatf("rand%0d cycle_cnt", idx), cycle_cnt, m_cyc);
        chk($sformatf("rand%0d start_cnt", idx), start_cnt, m_start);
        chk($sformatf("rand%0d ready_cnt", idx), ready_cnt, m_ready);
        chk($sformatf("rand%0d done_cnt", idx), done_cnt, m_done);
        chk($sformatf("rand%0d busy_cycles", idx), busy_cycles, m_busy);
        chk($sformatf("rand%0d stall_cycles", idx), stall_cycles, m_stall);
        chk($sformatf("rand%0d last_latency", idx), last_latency, m_lat);
        chk($sformatf("rand%0d finished", idx), finished, m_fin);
`ifdef NODF_EVENT_LOG_EN
        chk($sformatf("rand%0d evt_valid", idx), evt_valid, m_ev_v);
        if (m_ev_v) begin
            chk($sformatf("rand%0d evt_kind", idx), evt_kind, m_ev_k);
            chk($sformatf("rand%0d evt_time", idx), evt_time, m_ev_t);
        end
`endif
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int rst, s, rd, dn, ct, fz, n;
        int st, cyc, starts, readys, dones, busy, stall, lat, fin;
    } vec_t;

    vec_t tbl[$];

    initial begin
        drive(1, 0, 0, 0, 1, 0);

        // idle after reset
        tbl.push_back('{1,0,0,0,1,0,2,   0,0,0,0,0,0,0,0,0});
        tbl.push_back('{0,0,0,0,1,0,10,  0,10,0,0,0,0,0,0,0});
        // start at 5, done with continue at 12
        tbl.push_back('{1,0,0,0,1,0,1,   0,0,0,0,0,0,0,0,0});
        tbl.push_back('{0,0,0,0,1,0,5,   0,5,0,0,0,0,0,0,0});
        tbl.push_back('{0,1,0,0,1,0,1,   1,6,1,0,0,1,0,0,0});
        tbl.push_back('{0,0,0,0,1,0,6,   1,12,1,0,0,7,0,0,0});
        tbl.push_back('{0,0,0,1,1,0,1,   0,13,1,0,1,8,0,7,0});
        // done at 20 held with continue low, then continue
        tbl.push_back('{1,0,0,0,1,0,1,   0,0,0,0,0,0,0,0,0});
        tbl.push_back('{0,0,0,0,1,0,15,  0,15,0,0,0,0,0,0,0});
        tbl.push_back('{0,1,0,0,1,0,1,   1,16,1,0,0,1,0,0,0});
        tbl.push_back('{0,0,0,0,1,0,4,   1,20,1,0,0,5,0,0,0});
        tbl.push_back('{0,0,0,1,0,0,1,   2,21,1,0,1,6,0,5,0});
        tbl.push_back('{0,0,0,1,0,0,2,   2,23,1,0,1,6,2,5,0});
        tbl.push_back('{0,0,0,1,1,0,1,   0,24,1,0,1,6,3,5,0});
        // ready-only instance
        tbl.push_back('{1,0,0,0,1,0,1,   0,0,0,0,0,0,0,0,0});
        tbl.push_back('{0,0,1,0,1,0,4,   0,4,0,4,0,0,0,0,0});
        tbl.push_back('{0,0,0,0,1,0,1,   0,5,0,4,0,0,0,0,0});
        // back-to-back, then done while idle is ignored
        tbl.push_back('{1,0,0,0,1,0,1,   0,0,0,0,0,0,0,0,0});
        tbl.push_back('{0,1,0,0,1,0,1,   1,1,1,0,0,1,0,0,0});
        tbl.push_back('{0,0,0,0,1,0,2,   1,3,1,0,0,3,0,0,0});
        tbl.push_back('{0,1,0,1,1,0,1,   1,4,2,0,1,4,0,3,0});
        tbl.push_back('{0,0,0,1,1,0,1,   0,5,2,0,2,5,0,1,0});
        tbl.push_back('{0,0,0,1,1,0,2,   0,7,2,0,2,5,0,1,0});
        // latency truncated to LAT_W bits: 71 mod 64
        tbl.push_back('{1,0,0,0,1,0,1,   0,0,0,0,0,0,0,0,0});
        tbl.push_back('{0,1,0,0,1,0,1,   1,1,1,0,0,1,0,0,0});
        tbl.push_back('{0,0,0,0,1,0,70,  1,71,1,0,0,71,0,0,0});
        tbl.push_back('{0,0,0,1,1,0,1,   0,72,1,0,1,72,0,7,0});
        // counter saturation, cycle_cnt wrap
        tbl.push_back('{1,0,0,0,1,0,1,   0,0,0,0,0,0,0,0,0});
        tbl.push_back('{0,0,1,0,1,0,300, 0,44,0,255,0,0,0,0,0});
        // finish mid-run, later activity frozen, reset leaves FINISHED
        tbl.push_back('{1,0,0,0,1,0,1,   0,0,0,0,0,0,0,0,0});
        tbl.push_back('{0,1,0,0,1,0,1,   1,1,1,0,0,1,0,0,0});
        tbl.push_back('{0,0,0,0,1,0,2,   1,3,1,0,0,3,0,0,0});
        tbl.push_back('{0,0,1,0,1,1,1,   3,4,1,1,0,4,0,0,1});
        tbl.push_back('{0,1,1,1,1,0,5,   3,4,1,1,0,4,0,0,1});
        tbl.push_back('{0,1,1,1,1,1,2,   3,4,1,1,0,4,0,0,1});
        tbl.push_back('{1,0,0,0,1,0,1,   0,0,0,0,0,0,0,0,0});
        tbl.push_back('{0,0,0,0,1,0,1,   0,1,0,0,0,0,0,0,0});

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                drive(tbl[i].rst != 0, tbl[i].s != 0, tbl[i].rd != 0,
                      tbl[i].dn != 0, tbl[i].ct != 0, tbl[i].fz != 0);
                tick();
            end
            chk($sformatf("vec%0d state", i), state, tbl[i].st);
            chk($sformatf("vec%0d cycle_cnt", i), cycle_cnt, tbl[i].cyc);
            chk($sformatf("vec%0d start_cnt", i), start_cnt, tbl[i].starts);
            chk($sformatf("vec%0d ready_cnt", i), ready_cnt, tbl[i].readys);
            chk($sformatf("vec%0d done_cnt", i), done_cnt, tbl[i].dones);
            chk($sformatf("vec%0d busy_cycles", i), busy_cycles, tbl[i].busy);
            chk($sformatf("vec%0d stall_cycles", i), stall_cycles, tbl[i].stall);
            chk($sformatf("vec%0d last_latency", i), last_latency, tbl[i].lat);
            chk($sformatf("vec%0d finished", i), finished, tbl[i].fin);
        end

        // hand sequence: restart directly out of WAIT_CONT
        drive(1, 0, 0, 0, 1, 0); tick();
        drive(0, 1, 0, 0, 1, 0); tick();
        drive(0, 0, 0, 1, 0, 0); tick();
        chk("wait_restart state_wait", state, 2);
        drive(0, 1, 0, 0, 1, 0); tick();
        chk("wait_restart state_run", state, 1);
        chk("wait_restart start_cnt", start_cnt, 2);
        chk("wait_restart stall_cycles", stall_cycles, 1);
        chk("wait_restart busy_cycles", busy_cycles, 3);
        chk("wait_restart last_latency", last_latency, 1);

`ifdef NODF_EVENT_LOG_EN
        // hand sequence: done and start together log only the done
        drive(1, 0, 0, 0, 1, 0); tick();
        chk("evt reset valid", evt_valid, 0);
        drive(0, 1, 0, 0, 1, 0); tick();
        chk("evt start valid", evt_valid, 1);
        chk("evt start kind", evt_kind, 0);
        chk("evt start time", evt_time, 0);
        drive(0, 1, 1, 1, 1, 0); tick();
        chk("evt b2b valid", evt_valid, 1);
        chk("evt b2b kind", evt_kind, 2);
        chk("evt b2b time", evt_time, 1);
        chk("evt b2b start_cnt", start_cnt, 2);
        chk("evt b2b ready_cnt", ready_cnt, 1);
        drive(0, 0, 0, 0, 1, 0); tick();
        chk("evt single pulse", evt_valid, 0);
`endif

        // randomized run against the model
        drive(1, 0, 0, 0, 1, 0);
        tick();
        model_reset();
        for (int i = 0; i < 2500; i++) begin
            bit r, s, rd, dn, ct, fz;
            r  = (m_phase == 3) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 999) == 0);
            fz = ($urandom_range(0, 599) == 0);
            s  = ($urandom_range(0, 9) < 3);
            rd = ($urandom_range(0, 9) < 4);
            dn = ($urandom_range(0, 9) < 3);
            ct = ($urandom_range(0, 9) < 7);
            drive(r, s, rd, dn, ct, fz);
            @(posedge clock);
            model_step(r, s, rd, dn, ct, fz);
            #1;
            check_model(i);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nodf_module_status_tracker.md
Name: nodf_module_status_tracker

Overview:
Synthesizable status tracker for one non-dataflow HLS module's ap_ctrl handshake (ap_start/ap_ready/ap_done/ap_continue). Observes the handshake passively and keeps transaction state, counters and last-transaction latency for a simulation/debug monitor to sample. Sits beside the monitored module and never drives its handshake. Instances with unused handshake inputs tie them to constant 0 or 1.

Parameters:
CNT_W, 32, width of the timestamp and all counters.
LAT_W, 32, width of the last-latency register.

Ports:
clock  in  1  single clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
ap_start  in  1  start request of the monitored module.
ap_ready  in  1  ready pulse: module accepted inputs.
ap_done  in  1  done indication of the monitored module.
ap_continue  in  1  downstream continue; tie to 1 if unused.
finish  in  1  end-of-simulation request; freezes all tracking.
state  out  2  0=IDLE, 1=RUN, 2=WAIT_CONT, 3=FINISHED.
cycle_cnt  out  CNT_W  cycles since reset release.
start_cnt  out  CNT_W  accepted starts.
ready_cnt  out  CNT_W  ap_ready cycles.
done_cnt  out  CNT_W  completed transactions.
busy_cycles  out  CNT_W  cycles spent in RUN.
stall_cycles  out  CNT_W  cycles spent in WAIT_CONT.
last_latency  out  LAT_W  start-to-done cycles of the most recent transaction.
finished  out  1  sticky; high once finish is seen.

Behaviour:
- Reset: all outputs 0, state IDLE, finished 0. Reset overrides everything, including an in-flight transaction or the FINISHED state.
- cycle_cnt: +1 every non-reset cycle while not FINISHED; wraps modulo 2^CNT_W.
- All other counters saturate at all-ones and never wrap.
- IDLE: ap_start=1 -> RUN; start_cnt+1; latch start timestamp = cycle_cnt.
- RUN: busy_cycles+1 each cycle spent in RUN, including the exit cycle. On ap_done=1:
  - done_cnt+1; last_latency = cycle_cnt - start timestamp (modulo arithmetic, truncated to LAT_W).
  - ap_continue=1 and ap_start=1 -> stay in RUN; count a new start and relatch the timestamp (back-to-back transaction).
  - ap_continue=1 and ap_start=0 -> IDLE.
  - ap_continue=0 -> WAIT_CONT.
- WAIT_CONT: stall_cycles+1 each cycle; ap_done held high does not count again. ap_continue=1 -> IDLE, or -> RUN with a counted start if ap_start=1 in the same cycle.
- ap_ready: ready_cnt+1 every cycle it is high in any non-FINISHED state, independent of the state machine (ready-only instances rely on this).
- finish=1 in any state -> FINISHED next cycle; finished=1; all counters and last_latency freeze. Events in that same cycle are still counted. Only reset leaves FINISHED.
- ap_done in IDLE is ignored; it does not count as a done.
- Outputs are registered; each reflects an event one cycle after the event's edge.

Optional Feature:
NODF_EVENT_LOG_EN: when defined, adds outputs evt_valid (1), evt_kind (2: 0=start, 1=ready, 2=done, 3=finish) and evt_time (CNT_W).
- evt_valid pulses for one cycle per counted event; evt_time carries cycle_cnt at the event.
- Same-cycle events are reported by priority finish > done > start > ready; lower-priority events in that cycle are dropped from the log but still counted.
- When undefined, these ports and their logic do not exist.

Decomposition:
- Package nodf_status_pkg: state enum (IDLE/RUN/WAIT_CONT/FINISHED), evt_kind enum, default CNT_W/LAT_W constants.
- One sub-module, nodf_sat_counter: parameterized saturating counter with enable, used for every counter except cycle_cnt.

Test Plan:
- Reset then idle 10 cycles -> cycle_cnt=10, all other counters 0, state IDLE.
- start at cycle 5, done with continue=1 at cycle 12 -> start_cnt=1, done_cnt=1, last_latency=7, busy_cycles=8, state IDLE.
- done at cycle 20 with continue=0 for 3 cycles, then continue=1 -> stall_cycles=3, done_cnt=1 (held done not recounted), state IDLE.
- ap_ready high 4 cycles with start/done tied 0 -> ready_cnt=4, start_cnt=0, state IDLE.
- finish mid-RUN, then further start/ready/done pulses -> finished=1, state FINISHED, counters frozen; reset -> all 0.
- With NODF_EVENT_LOG_EN: done and start in the same cycle -> one evt_valid pulse with evt_kind=2; start_cnt still increments.
